// File: rtl/mult8u_product_accum_if.sv
// Handshake bundle for the product accumulator: product stream in, frame result out.
// clr travels with the bus because whoever drives the stream also aborts frames.
interface mult8u_product_accum_if #(
  parameter int unsigned ACC_W = 24
);
  logic             clr;
  logic [15:0]      product;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output clr, product, in_valid, out_ready,
    input  in_ready, out_sum, out_ovf, out_valid
  );

  modport slave (
    input  clr, product, in_valid, out_ready,
    output in_ready, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/mult8u_product_accum.sv
// Sums LEN unsigned 16-bit products per frame and presents the sum until it is taken.
// Define MULT8U_ACCUM_SAT_EN to saturate the sum on overflow instead of wrapping.
module mult8u_product_accum #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN   = 8
) (
  input logic                   clk,
  input logic                   rst,
  mult8u_product_accum_if.slave bus
);
  localparam int unsigned CntW = $clog2(LEN);
  localparam logic [CntW-1:0]  CntLast = CntW'(LEN - 1);
  localparam logic [ACC_W-1:0] SumMax  = '1;

  localparam logic StAcc  = 1'b0;
  localparam logic StHold = 1'b1;

  logic             state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] add_sum;

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

  assign accept   = bus.in_valid & bus.in_ready & ~bus.clr;
  assign add_full = {1'b0, sum_q} + {{(ACC_W - 15){1'b0}}, bus.product};
  assign carry    = add_full[ACC_W];

`ifdef MULT8U_ACCUM_SAT_EN
  // Once clamped at all-ones, any further nonzero product carries again, so it stays clamped.
  assign add_sum = carry ? SumMax : add_full[ACC_W-1:0];
`else
  assign add_sum = add_full[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      state_d = StAcc;
      cnt_d   = '0;
      sum_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == StAcc) begin
      if (accept) begin
        sum_d = add_sum;
        ovf_d = ovf_q | carry;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else if (bus.out_ready) begin
      // Result taken: the next frame starts from a zero sum.
      state_d = StAcc;
      sum_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAcc;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mult8u_product_accum.sv
// Bench for mult8u_product_accum: a default instance and an ACC_W=17/LEN=3 instance share
// one stimulus stream; a frame-level model tracks both every cycle.
module tb_mult8u_product_accum;
  localparam int unsigned W0 = 24;
  localparam int unsigned L0 = 8;
  localparam int unsigned W1 = 17;
  localparam int unsigned L1 = 3;
`ifdef MULT8U_ACCUM_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] product = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  mult8u_product_accum_if #(.ACC_W(W0)) b0 ();
  mult8u_product_accum_if #(.ACC_W(W1)) b1 ();

  assign b0.clr = clr;
  assign b0.product = product;
  assign b0.in_valid = in_valid;
  assign b0.out_ready = out_ready;
  assign b1.clr = clr;
  assign b1.product = product;
  assign b1.in_valid = in_valid;
  assign b1.out_ready = out_ready;

  mult8u_product_accum #(.ACC_W(W0), .LEN(L0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mult8u_product_accum #(.ACC_W(W1), .LEN(L1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  // Frame-level reference: running total of accepted products, result derived on completion.
  bit     m_hold [2];
  int     m_cnt  [2];
  longint m_tot  [2];
  longint r_sum  [2];
  bit     r_ovf  [2];
  int     frames [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_hold[d] = 1'b0;
    m_cnt[d]  = 0;
    m_tot[d]  = 0;
  endtask

  task automatic step(input int d, input logic irdy, input logic ovld, input logic [63:0] osum,
                      input logic oovf);
    longint w   = (d == 0) ? longint'(W0) : longint'(W1);
    int     len = (d == 0) ? L0 : L1;
    longint mx  = (longint'(1) << w) - 1;
    if (rst) begin
      chk($sformatf("d%0d_rst_ready", d), 64'(irdy), 64'd1);
      chk($sformatf("d%0d_rst_valid", d), 64'(ovld), 64'd0);
      chk($sformatf("d%0d_rst_sum", d), osum, 64'd0);
      chk($sformatf("d%0d_rst_ovf", d), 64'(oovf), 64'd0);
      model_reset(d);
      return;
    end
    chk($sformatf("d%0d_in_ready", d), 64'(irdy), 64'(!m_hold[d]));
    chk($sformatf("d%0d_out_valid", d), 64'(ovld), 64'(m_hold[d]));
    if (m_hold[d]) begin
      chk($sformatf("d%0d_out_sum", d), osum, 64'(r_sum[d]));
      chk($sformatf("d%0d_out_ovf", d), 64'(oovf), 64'(r_ovf[d]));
    end
    // Effect of the coming rising edge.
    if (clr) begin
      model_reset(d);
    end else if (!m_hold[d]) begin
      if (in_valid) begin
        m_tot[d] += longint'(product);
        m_cnt[d]++;
        if (m_cnt[d] == len) begin
          m_hold[d] = 1'b1;
          m_cnt[d]  = 0;
          r_ovf[d]  = (m_tot[d] > mx);
          if (!r_ovf[d]) r_sum[d] = m_tot[d];
          else if (Sat)  r_sum[d] = mx;
          else           r_sum[d] = m_tot[d] % (mx + 1);
          frames[d]++;
        end
      end
    end else if (out_ready) begin
      m_hold[d] = 1'b0;
      m_tot[d]  = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step(0, b0.in_ready, b0.out_valid, 64'(b0.out_sum), b0.out_ovf);
    step(1, b1.in_ready, b1.out_valid, 64'(b1.out_sum), b1.out_ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] p);
    in_valid = 1'b1;
    product  = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Called just after a rising edge; reset is asserted and released before the falling edge.
  task automatic async_rst(input string tag);
    #1 rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 64'(b0.out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(b0.in_ready), 64'd1);
    chk({tag, "_sum"}, 64'(b0.out_sum), 64'd0);
    model_reset(0);
    model_reset(1);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0][15:0] p;
    bit               gap;
    longint           sum;
    bit               ovf;
  } vec_t;

  vec_t tv [5];

  initial begin
    tv[0].p = {8{16'd65025}}; tv[0].gap = 1'b0; tv[0].sum = 520200; tv[0].ovf = 1'b0;
    for (int i = 0; i < 8; i++) tv[1].p[i] = 16'(i + 1);
    tv[1].gap = 1'b1; tv[1].sum = 36; tv[1].ovf = 1'b0;
    tv[2].p = '0; tv[2].gap = 1'b0; tv[2].sum = 0; tv[2].ovf = 1'b0;
    tv[3].p = {8{16'hFFFF}}; tv[3].gap = 1'b1; tv[3].sum = 524280; tv[3].ovf = 1'b0;
    for (int i = 0; i < 8; i++) tv[4].p[i] = 16'(1 << i);
    tv[4].gap = 1'b0; tv[4].sum = 255; tv[4].ovf = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      frames[d] = 0;
      r_sum[d] = 0;
      r_ovf[d] = 1'b0;
    end

    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Table vectors: one full frame each on the default instance.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      do_clr();
      for (int i = 0; i < 8; i++) begin
        if (tv[v].gap && i > 0) idle(1);
        feed(tv[v].p[i]);
      end
      chk($sformatf("tv%0d_valid", v), 64'(b0.out_valid), 64'd1);
      chk($sformatf("tv%0d_sum", v), 64'(b0.out_sum), 64'(tv[v].sum));
      chk($sformatf("tv%0d_ovf", v), 64'(b0.out_ovf), 64'(tv[v].ovf));
      chk($sformatf("tv%0d_busy", v), 64'(b0.in_ready), 64'd0);
      idle(1);
      chk($sformatf("tv%0d_done_valid", v), 64'(b0.out_valid), 64'd0);
      chk($sformatf("tv%0d_done_ready", v), 64'(b0.in_ready), 64'd1);
    end

    // Narrow instance overflow: wraps or clamps depending on build.
    do_clr();
    out_ready = 1'b0;
    repeat (3) feed(16'd65025);
    chk("narrow_valid", 64'(b1.out_valid), 64'd1);
    chk("narrow_ovf", 64'(b1.out_ovf), 64'd1);
    chk("narrow_sum", 64'(b1.out_sum), Sat ? 64'd131071 : 64'd64003);
    out_ready = 1'b1;
    idle(1);

    // Stalled consumer: result held stable, no input accepted.
    do_clr();
    out_ready = 1'b0;
    repeat (8) feed(16'd500);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(b0.in_ready), 64'd0);
      chk("stall_sum", 64'(b0.out_sum), 64'd4000);
      in_valid = 1'b1;
      product  = 16'd9;
      tick();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    idle(1);
    chk("stall_rel_valid", 64'(b0.out_valid), 64'd0);
    chk("stall_rel_ready", 64'(b0.in_ready), 64'd1);

    // clr drops the coincident beat and the partial sum.
    do_clr();
    repeat (3) feed(16'd100);
    clr = 1'b1;
    feed(16'd7);
    clr = 1'b0;
    repeat (8) feed(16'd1);
    chk("clr_sum", 64'(b0.out_sum), 64'd8);
    chk("clr_ovf", 64'(b0.out_ovf), 64'd0);
    chk("clr_valid", 64'(b0.out_valid), 64'd1);
    idle(1);

    // Async reset mid-frame, then a full frame accepted from the first edge after release.
    do_clr();
    repeat (5) feed(16'd50);
    async_rst("rst_mid");
    repeat (8) feed(16'd2);
    chk("rst_mid_sum", 64'(b0.out_sum), 64'd16);
    chk("rst_mid_fvalid", 64'(b0.out_valid), 64'd1);
    // Async reset while holding a result.
    out_ready = 1'b0;
    idle(1);
    async_rst("rst_hold");
    out_ready = 1'b1;
    idle(1);

    // Random traffic, checked cycle by cycle by the model on both instances.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      product   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      tick();
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("frames0_seen", 64'(frames[0] > 8), 64'd1);
    chk("frames1_seen", 64'(frames[1] > 20), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult8u_product_accum.md
MULT8U_PRODUCT_ACCUM -- requirements
Module: mult8u_product_accum

Interface
REQ-001 Parameter ACC_W, default 24, accumulator and result width in bits; legal range 17..32.
REQ-002 Parameter LEN, default 8, number of products summed per frame; legal range 2..256.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port clr  input  1  synchronous frame abort: discard the partial sum and the held result.
REQ-006 Port product  input  16  unsigned product from the registered 8x8 multiplier stage.
REQ-007 Port in_valid  input  1  product is valid this cycle.
REQ-008 Port in_ready  output  1  block accepts product this cycle.
REQ-009 Port out_sum  output  ACC_W  completed frame sum.
REQ-010 Port out_ovf  output  1  frame overflowed ACC_W bits.
REQ-011 Port out_valid  output  1  out_sum and out_ovf are valid.
REQ-012 Port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 The block SHALL have two states: ACC (collecting) and HOLD (result presented).
REQ-014 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1. Both are registered-state decodes; in_ready SHALL NOT depend combinationally on in_valid or out_ready.
REQ-015 Beat accept SHALL be in_valid AND in_ready; only accepted beats change the sum or the beat counter.
REQ-016 On accept, the sum SHALL be zero-extended product plus the running sum; the first beat of a frame SHALL start from 0.
REQ-017 A beat counter SHALL run 0..LEN-1. The accept at count LEN-1 SHALL move the block to HOLD and reset the counter to 0. The final sum SHALL appear on out_sum with out_valid=1 on the next cycle (latency 1 cycle from the last accept).
REQ-018 out_ovf SHALL be set if any addition in the frame carried beyond ACC_W bits, and SHALL stay set for the rest of the frame.
REQ-019 In HOLD, out_sum and out_ovf SHALL stay stable until out_valid AND out_ready. The next cycle SHALL return to ACC with out_valid=0. No bubble-free overlap: the first beat of the next frame is accepted no earlier than that cycle.
REQ-020 clr SHALL have priority over accept and handshake. The next cycle it SHALL give state ACC, counter 0, sum 0, ovf 0, out_valid 0. A beat presented with clr SHALL be dropped, even though in_ready may be 1.
REQ-021 If in_valid is low mid-frame, the counter and sum SHALL hold; there is no timeout.

Reset
REQ-022 While rst=1, asynchronously: state ACC, counter 0, sum 0, out_sum 0, out_ovf 0, out_valid 0, in_ready 1 after release. This SHALL apply even mid-frame or in HOLD; a partial frame is lost.
REQ-023 The first accept is possible on the first rising clk edge after rst deasserts.

Configuration
REQ-024 Macro MULT8U_ACCUM_SAT_EN: when defined, an overflowing addition SHALL clamp the sum to 2^ACC_W-1, and it SHALL stay clamped for the rest of the frame.
REQ-025 Without MULT8U_ACCUM_SAT_EN, the sum SHALL wrap modulo 2^ACC_W. out_ovf behaviour SHALL be identical in both builds.

Verification
REQ-026 Defaults; 8 beats of product=65025 back-to-back, out_ready=1 -> one cycle after the 8th accept: out_sum=520200 (0x7F008), out_ovf=0, out_valid=1 for 1 cycle.
REQ-027 ACC_W=17, LEN=3; 3 beats of 65025 -> out_ovf=1. out_sum=64003 without the macro; 131071 with MULT8U_ACCUM_SAT_EN.
REQ-028 Defaults; complete a frame with out_ready=0 for 5 cycles -> in_ready=0 and out_sum stable throughout. out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-029 Defaults; 3 beats of 100, then clr together with in_valid and product=7, then 8 beats of 1 -> out_sum=8, out_ovf=0.
REQ-030 Defaults; assert rst asynchronously (between edges) after 5 beats -> out_valid=0 and in_ready=1 immediately. The next 8 beats of 2 -> out_sum=16.
REQ-031 Defaults; in_valid toggled 1/0 every cycle with products 1..8 -> out_sum=36 one cycle after the 8th accept.
